// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state encoding, opcodes and datapath select codes for multicycle_ctrl.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
    S_ALUWB, S_BRANCH, S_IMM_EXEC, S_IMM_WB, S_JUMP, S_ERR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_sel;
    logic       illegal_op;
  } ctrl_t;

  // Unrecognised opcodes map back to FETCH; the caller flags them as illegal.
  function automatic state_t decode_next(input logic [5:0] op);
    return (op == OP_LW || op == OP_SW)                    ? S_MEMADR   :
           (op == OP_RTYPE)                                ? S_EXEC_R   :
           (op == OP_BEQ)                                  ? S_BRANCH   :
           (op == OP_J)                                    ? S_JUMP     :
           (op inside {OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI}) ? S_IMM_EXEC :
                                                             S_FETCH;
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS control FSM with memory-ack timeout.
// Define ZERO_EXT_EN to zero-extend immediates of andi/ori.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       ext_sel,
  output logic       illegal_op,
  output logic       mem_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_err_q, mem_err_d;
  logic          mem_st, timeout;
  ctrl_t         c, o;
  logic          unused_funct;

  assign unused_funct = ^funct;
  assign mem_st  = state_q inside {S_FETCH, S_MEMRD, S_MEMWR};
  // An ack in the limit cycle wins over the timeout.
  assign timeout = mem_st && !mem_ack && cnt_q == LAST;

  always_comb begin
    state_d = state_q;
    c       = '0;
    case (state_q)
      S_FETCH: begin
        c.mem_req = 1'b1;
        if (mem_ack) begin
          c.ir_we     = 1'b1;
          c.pc_we     = 1'b1;
          c.alu_src_b = SRCB_FOUR;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        c.alu_src_b  = SRCB_IMM_SH;
        state_d      = decode_next(opcode);
        c.illegal_op = state_d == S_FETCH;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        state_d     = opcode == OP_LW ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        state_d   = mem_ack ? S_MEMWB : S_MEMRD;
      end
      S_MEMWR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
        state_d   = mem_ack ? S_FETCH : S_MEMWR;
      end
      S_MEMWB: begin
        c.reg_we     = 1'b1;
        c.mem_to_reg = 1'b1;
        state_d      = S_FETCH;
      end
      S_EXEC_R: begin
        c.alu_op = ALU_FUNCT;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        c.reg_we  = 1'b1;
        c.reg_dst = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_op = ALU_SUB;
        c.pc_src = PC_ALUOUT;
        c.pc_we  = alu_zero;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        c.pc_we  = 1'b1;
        c.pc_src = PC_JUMP;
        state_d  = S_FETCH;
      end
      S_IMM_EXEC: begin
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_IMM;
`ifdef ZERO_EXT_EN
        c.ext_sel   = opcode inside {OP_ANDI, OP_ORI};
`else
        c.ext_sel   = 1'b0;
`endif
        state_d     = S_IMM_WB;
      end
      S_IMM_WB: begin
        c.reg_we = 1'b1;
        state_d  = S_FETCH;
      end
      default: ;
    endcase
    if (timeout) state_d = S_ERR;
    mem_err_d = mem_err_q | timeout;
    // Every state change is an entry, so the wait count restarts on any transition.
    cnt_d = state_d != state_q ? '0 : (mem_st && !mem_ack) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign o          = rst_n ? c : '0;
  assign mem_req    = o.mem_req;
  assign mem_we     = o.mem_we;
  assign iord       = o.iord;
  assign ir_we      = o.ir_we;
  assign pc_we      = o.pc_we;
  assign reg_we     = o.reg_we;
  assign reg_dst    = o.reg_dst;
  assign mem_to_reg = o.mem_to_reg;
  assign alu_src_a  = o.alu_src_a;
  assign pc_src     = o.pc_src;
  assign alu_src_b  = o.alu_src_b;
  assign alu_op     = o.alu_op;
  assign ext_sel    = o.ext_sel;
  assign illegal_op = o.illegal_op;
  assign mem_err    = rst_n & mem_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level reference model checking every cycle of multicycle_ctrl.
module tb_multicycle_ctrl;

  localparam logic [5:0] RT = 6'b000000, J = 6'b000010, BEQ = 6'b000100, ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010, ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;

  logic clk = 1'b0, rst_n, alu_zero, mem_ack;
  logic [5:0] opcode, funct;
  logic mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic ext_sel, illegal_op, mem_err;
  logic [17:0] obs;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
    .pc_we(pc_we), .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .ext_sel(ext_sel), .illegal_op(illegal_op), .mem_err(mem_err)
  );

  assign obs = {mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg, alu_src_a,
                pc_src, alu_src_b, alu_op, ext_sel, illegal_op, mem_err};

  function automatic logic [17:0] pk(input logic mr, mw, io, ir, pw, rw, rd, m2r, asa,
                                     input logic [1:0] ps, asb, ao,
                                     input logic es, il, me);
    return {mr, mw, io, ir, pw, rw, rd, m2r, asa, ps, asb, ao, es, il, me};
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op inside {RT, J, BEQ, ADDI, SLTI, ANDI, ORI, LW, SW};
  endfunction

  task automatic chk(input string tag, input logic [17:0] exp);
    @(negedge clk);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%b want=%b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_ack  = 1'($urandom);
    alu_zero = 1'($urandom);
  endtask

  task automatic fetch(input int d);
    for (int i = 0; i < d; i++) begin
      mem_ack = 1'b0;
      chk("fetch_wait", pk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0));
    end
    mem_ack = 1'b1;
    chk("fetch_ack", pk(1,0,0,1,1,0,0,0,0,2'b00,2'b01,2'b00,0,0,0));
  endtask

  task automatic mem_wait(input logic we, input int d);
    for (int i = 0; i < d; i++) begin
      mem_ack = 1'b0;
      chk(we ? "memwr_wait" : "memrd_wait", pk(1,we,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0));
    end
  endtask

  task automatic mem_access(input logic we, input int d);
    mem_wait(we, d);
    mem_ack = 1'b1;
    chk(we ? "memwr_ack" : "memrd_ack", pk(1,we,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0));
  endtask

  task automatic decode(input logic il);
    idle_inputs();
    chk(il ? "decode_illegal" : "decode", pk(0,0,0,0,0,0,0,0,0,2'b00,2'b11,2'b00,0,il,0));
  endtask

  task automatic memadr();
    idle_inputs();
    chk("memadr", pk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0));
  endtask

  task automatic run(input logic [5:0] op, input int fd, input int md, input logic z);
    logic zx;
`ifdef ZERO_EXT_EN
    zx = op == ANDI || op == ORI;
`else
    zx = 1'b0;
`endif
    opcode = op;
    funct  = 6'($urandom);
    fetch(fd);
    decode(!legal(op));
    if (op == LW || op == SW) begin
      memadr();
      mem_access(op == SW, md);
      if (op == LW) begin
        idle_inputs();
        chk("memwb", pk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0,0));
      end
    end else if (op == RT) begin
      idle_inputs();
      chk("exec_r", pk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0,0,0));
      idle_inputs();
      chk("aluwb", pk(0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0,0,0));
    end else if (op == BEQ) begin
      mem_ack  = 1'($urandom);
      alu_zero = z;
      chk("branch", pk(0,0,0,0,z,0,0,0,0,2'b01,2'b00,2'b01,0,0,0));
    end else if (op == J) begin
      idle_inputs();
      chk("jump", pk(0,0,0,0,1,0,0,0,0,2'b10,2'b00,2'b00,0,0,0));
    end else if (legal(op)) begin
      idle_inputs();
      chk("imm_exec", pk(0,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b11,zx,0,0));
      idle_inputs();
      chk("imm_wb", pk(0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0,0,0));
    end
  endtask

  initial begin
    logic [5:0] ops [9];
    logic [5:0] op;
    ops = '{RT, J, BEQ, ADDI, SLTI, ANDI, ORI, LW, SW};
    rst_n = 1'b0; mem_ack = 1'b1; opcode = LW; funct = '0; alu_zero = 1'b0;
    chk("reset", '0);
    chk("reset", '0);
    rst_n = 1'b1;
    run(LW, 2, 2, 0);
    run(BEQ, 0, 0, 1);
    run(BEQ, 1, 0, 0);
    run(ORI, 0, 0, 0);
    run(ANDI, 1, 0, 0);
    run(ADDI, 0, 0, 0);
    run(6'b111111, 0, 0, 0);
    run(LW, 14, 14, 0);
    run(SW, 3, 1, 0);
    run(RT, 0, 0, 0);
    run(J, 2, 0, 0);
    run(SLTI, 0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 9) begin
        do op = 6'($urandom); while (legal(op));
      end else op = ops[r];
      run(op, $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom));
    end
    opcode = LW;
    fetch(0);
    decode(0);
    memadr();
    mem_wait(1'b0, 15);
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      chk("err", pk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,1));
    end
    rst_n = 1'b0;
    chk("rst_in_err", '0);
    rst_n = 1'b1; mem_ack = 1'b0;
    chk("fetch_after_err", pk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0));
    run(ADDI, 0, 0, 0);
    opcode = SW;
    fetch(1);
    decode(0);
    memadr();
    mem_wait(1'b1, 2);
    rst_n = 1'b0; mem_ack = 1'b1;
    chk("rst_mid_memwr", '0);
    rst_n = 1'b1; mem_ack = 1'b0;
    chk("fetch_after_rst", pk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0));
    run(ORI, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
